// File: rtl/nand_feeder_pkg.sv
// Shared definitions for the NAND page feeder: FSM encodings, underrun limit, default command address.
package nand_feeder_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CMD       = 3'd1;
  localparam state_t ST_STREAM    = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  localparam int         UNDERRUN_LIMIT = 4096;
  localparam logic [7:0] DEF_CMD_ADDR   = 8'h02;
endpackage

// File: rtl/nand_page_feeder_fifo.sv
// Synchronous word FIFO holding exactly DEPTH entries (power of two); push and pop may coincide.
module nand_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop & !empty;
    // A pop frees the head slot in the same cycle, so a push at full is still safe then.
    do_push = push & (!full | do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/nand_page_feeder.sv
// Page program front end: issues the command write, buffers source words, streams them to the engine.
// Optional running XOR checksum output enabled by NAND_FEEDER_CKSUM_EN.
module nand_page_feeder
  import nand_feeder_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 16,
  parameter int         PAGE_WORDS    = 512,
  parameter logic [7:0] CMD_ADDR      = DEF_CMD_ADDR,
  parameter int         CMD_WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] page_addr_i,
  input  logic [31:0] src_dat_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] eng_dat_o,
  output logic        eng_strobe_o,
  input  logic        eng_take_i,
  input  logic        eng_done_i,
  output logic        ctrl_cs_o,
  output logic        ctrl_wr_o,
  output logic [7:0]  ctrl_addr_o,
  output logic [15:0] ctrl_data_o
`ifdef NAND_FEEDER_CKSUM_EN
  ,
  output logic [31:0] cksum_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PAGE_WORDS) + 1;
  localparam int WW = $clog2(CMD_WR_CYCLES) + 1;
  localparam int UW = $clog2(UNDERRUN_LIMIT) + 1;
  localparam logic [CW-1:0] PAGE_CNT  = CW'(PAGE_WORDS);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [WW-1:0] WR_CYC    = WW'(CMD_WR_CYCLES);
  localparam logic [UW-1:0] UR_LAST   = UW'(UNDERRUN_LIMIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] acc_q, acc_d, sent_q, sent_d;
  logic [WW-1:0] wr_cnt_q, wr_cnt_d;
  logic [UW-1:0] ur_q, ur_d;
  logic          err_q, err_d, ready_q, ready_d, wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]   fifo_rdata;
  logic [AW:0]   fifo_cnt, cnt_nxt;

  nand_word_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (src_dat_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;
  assign src_ready_o  = ready_q;
  assign eng_strobe_o = (state_q == ST_STREAM) & !fifo_empty;
  assign eng_dat_o    = eng_strobe_o ? fifo_rdata : '0;
  assign ctrl_cs_o    = 1'b1;
  assign ctrl_wr_o    = wr_q;
  assign ctrl_addr_o  = addr_q;
  assign ctrl_data_o  = data_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sent_d     = sent_q;
    wr_cnt_d   = wr_cnt_q;
    ur_d       = '0;
    err_d      = 1'b0;
    wr_d       = 1'b0;
    fifo_flush = 1'b0;
    // Address/data linger one cycle after Wr drops, then clear.
    addr_d     = wr_q ? addr_q : '0;
    data_d     = wr_q ? data_q : '0;
    fifo_push  = src_valid_i & ready_q & !fifo_full;
    fifo_pop   = eng_take_i & eng_strobe_o;
    if (fifo_push && acc_q != PAGE_CNT)  acc_d  = acc_q + 1'b1;
    if (fifo_pop  && sent_q != PAGE_CNT) sent_d = sent_q + 1'b1;

    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d  = ST_CMD;
        wr_d     = 1'b1;
        wr_cnt_d = WW'(1);
        addr_d   = CMD_ADDR;
        data_d   = page_addr_i;
        acc_d    = '0;
        sent_d   = '0;
      end
      ST_CMD: if (wr_cnt_q < WR_CYC) begin
        wr_d     = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
      end else begin
        state_d  = ST_STREAM;
      end
      ST_STREAM: if (sent_q == PAGE_CNT) begin
        state_d = ST_WAIT_DONE;
      end else if (fifo_empty && !src_valid_i) begin
        if (ur_q == UR_LAST) begin
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          ur_d = ur_q + 1'b1;
        end
      end
      ST_WAIT_DONE: if (eng_done_i) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Ready is computed from next-cycle occupancy so the registered flag never overfills.
    cnt_nxt = fifo_flush ? '0 : fifo_cnt + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
    ready_d = (state_d != ST_IDLE) & (cnt_nxt < DEPTH_CNT) & (acc_d < PAGE_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      sent_q   <= '0;
      wr_cnt_q <= '0;
      ur_q     <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sent_q   <= sent_d;
      wr_cnt_q <= wr_cnt_d;
      ur_q     <= ur_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

`ifdef NAND_FEEDER_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == ST_IDLE && start_i) cksum_d = '0;
    else if (fifo_pop)                 cksum_d = cksum_q ^ fifo_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign cksum_o = cksum_q;
`endif
endmodule

// File: tb/tb_nand_page_feeder.sv
// Directed bench for nand_page_feeder with FIFO_DEPTH = 4, PAGE_WORDS = 4.
module tb_nand_page_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] page_addr_i;
  logic [31:0] src_dat_i;
  logic        src_valid_i;
  logic        src_ready_o, busy_o, done_o, err_o;
  logic [31:0] eng_dat_o;
  logic        eng_strobe_o, eng_take_i, eng_done_i;
  logic        ctrl_cs_o, ctrl_wr_o;
  logic [7:0]  ctrl_addr_o;
  logic [15:0] ctrl_data_o;
`ifdef NAND_FEEDER_CKSUM_EN
  logic [31:0] cksum_o;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nand_page_feeder #(.FIFO_DEPTH(4), .PAGE_WORDS(4), .CMD_ADDR(8'h02), .CMD_WR_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .page_addr_i  (page_addr_i),
    .src_dat_i    (src_dat_i),
    .src_valid_i  (src_valid_i),
    .src_ready_o  (src_ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .eng_dat_o    (eng_dat_o),
    .eng_strobe_o (eng_strobe_o),
    .eng_take_i   (eng_take_i),
    .eng_done_i   (eng_done_i),
    .ctrl_cs_o    (ctrl_cs_o),
    .ctrl_wr_o    (ctrl_wr_o),
    .ctrl_addr_o  (ctrl_addr_o),
    .ctrl_data_o  (ctrl_data_o)
`ifdef NAND_FEEDER_CKSUM_EN
    ,
    .cksum_o      (cksum_o)
`endif
  );

  typedef struct packed {
    logic        busy, wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        rdy, stb;
    logic [31:0] dat;
    logic        done, err, cs;
  } out_t;

  typedef struct {
    logic        start;
    logic [15:0] pa;
    logic        vld;
    logic [31:0] sd;
    logic        take, edone;
    out_t        exp;
  } vec_t;

  function automatic out_t cur();
    out_t o;
    o = '{busy_o, ctrl_wr_o, ctrl_addr_o, ctrl_data_o, src_ready_o, eng_strobe_o,
          eng_dat_o, done_o, err_o, ctrl_cs_o};
    return o;
  endfunction

  function automatic vec_t mk(logic st, logic [15:0] pa, logic v, logic [31:0] sd, logic tk,
                              logic ed, logic bz, logic wr, logic [7:0] a, logic [15:0] d,
                              logic rdy, logic stb, logic [31:0] dat, logic dn);
    vec_t r;
    r.start = st; r.pa = pa; r.vld = v; r.sd = sd; r.take = tk; r.edone = ed;
    r.exp = '{bz, wr, a, d, rdy, stb, dat, dn, 1'b0, 1'b1};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; page_addr_i = '0; src_dat_i = '0; src_valid_i = 0;
    eng_take_i = 0; eng_done_i = 0;
  endtask

  // One page of four words, engine optionally stalled for the first `stall` cycles.
  task automatic run_page(input string tag, input logic [3:0][31:0] w, input int stall);
    int          src_i, cyc, ndone;
    logic [31:0] got [$];
    start_i = 1; page_addr_i = 16'h1234; tick(); start_i = 0;
    src_i = 0; cyc = 0; ndone = 0;
    while (got.size() < 4 && cyc < 300) begin
      src_valid_i = (src_i < 4);
      src_dat_i   = '0;
      if (src_i < 4) src_dat_i = w[src_i];
      eng_take_i  = (cyc >= stall) && eng_strobe_o;
      if (stall > 0 && cyc == stall - 1)
        check({tag, "_stall_ready"}, 64'({src_ready_o, src_i}), 64'({1'b0, 32'd4}));
      if (src_valid_i && src_ready_o) src_i++;
      if (eng_take_i) got.push_back(eng_dat_o);
      tick(); cyc++;
      if (done_o) ndone++;
    end
    src_valid_i = 0; eng_take_i = 0;
    check({tag, "_nwords"}, 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_word%0d", tag, i), 64'((i < got.size()) ? got[i] : 32'hx), 64'(w[i]));
    repeat (100) begin
      tick();
      if (done_o) ndone++;
    end
    eng_done_i = 1; tick(); eng_done_i = 0;
    check({tag, "_done_pulse"}, 64'({done_o, busy_o}), 64'b11);
`ifdef NAND_FEEDER_CKSUM_EN
    check({tag, "_cksum"}, 64'(cksum_o), 64'(w[0] ^ w[1] ^ w[2] ^ w[3]));
`endif
    if (done_o) ndone++;
    tick();
    if (done_o) ndone++;
    check({tag, "_after_done"}, 64'({done_o, busy_o}), 64'b00);
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
  endtask

  initial begin
    vec_t        vecs [10];
    out_t        rst_out;
    logic [31:0] wb;
    int          t_empty, t_err, ndone, nbad;
    logic        seen;

    rst_out = '0; rst_out.cs = 1'b1;
    wb = 32'hABCDEF12;
    vecs[0] = mk(1, 16'hBABE, 0, 0,      0, 0, 1, 1, 8'h02, 16'hBABE, 1, 0, 0,      0);
    vecs[1] = mk(1, 16'hBABE, 1, wb,     1, 0, 1, 1, 8'h02, 16'hBABE, 1, 0, 0,      0);
    vecs[2] = mk(0, 16'h0,    1, wb + 1, 0, 0, 1, 0, 8'h02, 16'hBABE, 1, 1, wb,     0);
    vecs[3] = mk(0, 16'h0,    1, wb + 2, 1, 0, 1, 0, 8'h00, 16'h0000, 1, 1, wb + 1, 0);
    vecs[4] = mk(0, 16'h0,    1, wb + 3, 1, 0, 1, 0, 8'h00, 16'h0000, 0, 1, wb + 2, 0);
    vecs[5] = mk(0, 16'h0,    0, 0,      1, 1, 1, 0, 8'h00, 16'h0000, 0, 1, wb + 3, 0);
    vecs[6] = mk(0, 16'h0,    0, 0,      1, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 0,      0);
    vecs[7] = mk(0, 16'h0,    0, 0,      1, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 0,      0);
    vecs[8] = mk(0, 16'h0,    0, 0,      0, 1, 1, 0, 8'h00, 16'h0000, 0, 0, 0,      1);
    vecs[9] = mk(0, 16'h0,    0, 0,      0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0,      0);

    idle_inputs();
    rst = 1; tick(); tick();
    check("reset_state", 64'(cur()), 64'(rst_out));
    rst = 0;

    // Command write, repeated start ignored, early eng_done ignored, stray take ignored.
    for (int i = 0; i < 10; i++) begin
      start_i = vecs[i].start; page_addr_i = vecs[i].pa;
      src_valid_i = vecs[i].vld; src_dat_i = vecs[i].sd;
      eng_take_i = vecs[i].take; eng_done_i = vecs[i].edone;
      tick();
      check($sformatf("vec%0d", i), 64'(cur()), 64'(vecs[i].exp));
    end
    idle_inputs();
    tick();

    run_page("page", {wb + 32'd3, wb + 32'd2, wb + 32'd1, wb}, 0);
    run_page("stall", {32'h0D0D0004, 32'h0C0C0003, 32'h0B0B0002, 32'h0A0A0001}, 20);
`ifdef NAND_FEEDER_CKSUM_EN
    run_page("cksum", {32'd8, 32'd4, 32'd2, 32'd1}, 0);
`endif

    // Underrun: two words then silence.
    start_i = 1; page_addr_i = 16'h0042; tick(); start_i = 0;
    src_valid_i = 1; src_dat_i = 32'h11; tick();
    src_dat_i = 32'h22; tick();
    src_valid_i = 0;
    t_empty = -1; t_err = -1; ndone = 0; seen = 0;
    for (int c = 0; c < 6000 && t_err < 0; c++) begin
      eng_take_i = eng_strobe_o;
      if (eng_strobe_o) seen = 1;
      tick();
      if (done_o) ndone++;
      if (seen && !eng_strobe_o && t_empty < 0) t_empty = c;
      if (err_o) t_err = c;
    end
    eng_take_i = 0;
    check("underrun_seen", 64'({t_err >= 0, t_empty >= 0}), 64'b11);
    check("underrun_delay", 64'(t_err - t_empty), 64'd4096);
    tick();
    if (done_o) ndone++;
    check("underrun_idle", 64'(cur()), 64'(rst_out));
    check("underrun_no_done", 64'(ndone), 64'd0);

    // Reset in the middle of STREAM with words still buffered.
    start_i = 1; page_addr_i = 16'h7777; tick(); start_i = 0;
    src_valid_i = 1; src_dat_i = 32'h55; tick();
    src_dat_i = 32'h66; tick();
    src_valid_i = 0;
    check("pre_reset_stream", 64'({eng_strobe_o, busy_o}), 64'b11);
    rst = 1;
    tick(); check("midreset_c1", 64'(cur()), 64'(rst_out));
    tick(); check("midreset_c2", 64'(cur()), 64'(rst_out));
    rst = 0; eng_take_i = 1;
    nbad = 0;
    repeat (5) begin
      tick();
      if (cur() !== rst_out) nbad++;
    end
    eng_take_i = 0;
    check("post_reset_quiet", 64'(nbad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/nand_page_feeder.md
Name: nand_page_feeder

Overview:
- Upstream stage of cfi_ctrl_engine. Takes one page program request and issues the control-register command write on CtrlAddr/CtrlData/Wr.
- Buffers 32-bit source words in a FIFO and feeds them to the engine's bus_dat_i/bus_strobe_i word handshake.
- Reports completion when the engine returns bus_ack_done_o.

Parameters:
- FIFO_DEPTH, 16, word FIFO entries; power of two, ≥2
- PAGE_WORDS, 512, 32-bit words per page program
- CMD_ADDR, 8'h02, control register address for the program command
- CMD_WR_CYCLES, 2, clocks Wr is held high per command write

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; start page program
- page_addr_i  in  16  page address; sampled when start_i is accepted
- src_dat_i  in  32  source data word
- src_valid_i  in  1  source word valid
- src_ready_o  out  1  feeder accepts word (transfer = valid & ready)
- busy_o  out  1  request in progress
- done_o  out  1  one-cycle pulse; page finished
- err_o  out  1  one-cycle pulse; underrun abort
- eng_dat_o  out  32  to engine bus_dat_i
- eng_strobe_o  out  1  to engine bus_strobe_i; word valid
- eng_take_i  in  1  from engine bus_strobe_o; one-cycle pulse, head word consumed
- eng_done_i  in  1  from engine bus_ack_done_o; program finished
- ctrl_cs_o  out  1  to engine CS
- ctrl_wr_o  out  1  to engine Wr
- ctrl_addr_o  out  8  to engine CtrlAddr
- ctrl_data_o  out  16  to engine CtrlData

Behaviour:
- Reset values (applied on rst at a clk edge):
  - outputs: busy_o, done_o, err_o, eng_strobe_o, ctrl_wr_o, src_ready_o = 0; ctrl_cs_o = 1; eng_dat_o, ctrl_addr_o, ctrl_data_o = 0.
  - internal: FIFO pointers, count and word counters cleared; FSM to IDLE.
  - rst mid-operation aborts immediately; no done_o or err_o pulse.
- FSM states and transitions:
  - IDLE -> CMD on start_i; latches page_addr_i. start_i is ignored in any other state.
  - CMD: ctrl_wr_o = 1 for exactly CMD_WR_CYCLES clocks, with ctrl_addr_o = CMD_ADDR and ctrl_data_o = latched page address. ctrl_data_o returns to 0 the cycle after Wr drops. Then -> STREAM.
  - STREAM: feeds words to the engine (see handshakes). When sent_cnt reaches PAGE_WORDS -> WAIT_DONE.
  - WAIT_DONE: waits for eng_done_i, then -> DONE.
  - DONE: done_o = 1 for one cycle, then -> IDLE.
- Source side:
  - src_ready_o = busy_o & !fifo_full & (acc_cnt < PAGE_WORDS). Registered; no combinational path from src_valid_i.
  - Acceptance is allowed from the CMD state onward, so the FIFO prefills during the command write.
  - Push and pop in the same cycle are legal; count is unchanged and data order is preserved.
- Engine side:
  - eng_strobe_o = STREAM & !fifo_empty; eng_dat_o = FIFO head word.
  - eng_take_i pops the head; next word appears on the following cycle, so sustained rate is 1 word/clk.
  - eng_take_i while eng_strobe_o = 0 is ignored; no pop, no counter change.
- Counters: acc_cnt and sent_cnt are clog2(PAGE_WORDS)+1 bits, saturating at PAGE_WORDS. The FIFO pointers wrap modulo FIFO_DEPTH.
- Underrun:
  - In STREAM, if the FIFO is empty and src_valid_i is low for 4096 consecutive clocks, err_o pulses for one cycle.
  - The FIFO is flushed and the FSM returns to IDLE without a done_o pulse.
- eng_done_i before sent_cnt = PAGE_WORDS is ignored.
- Latency: start_i accepted -> ctrl_wr_o high on the next cycle. The first eng_strobe_o rises no earlier than CMD_WR_CYCLES+1 clocks after start_i.

Optional Feature:
- Macro: NAND_FEEDER_CKSUM_EN.
- Defined:
  - Adds output cksum_o [31:0], the running XOR of every word popped to the engine.
  - Cleared on start_i; holds its value from done_o until the next start_i.
  - Reset value 0.
- Undefined: no port, no logic.

Decomposition:
- Shared package nand_feeder_pkg:
  - FSM state enum (IDLE, CMD, STREAM, WAIT_DONE, DONE)
  - UNDERRUN_LIMIT = 4096
  - default CMD_ADDR
- Sub-module nand_word_fifo:
  - Synchronous FIFO, parameterised width/depth, with push/pop/full/empty/count.
  - Holds FIFO_DEPTH words (no extra slot).

Test Plan:
- Reset: assert rst for 2 clocks mid-STREAM -> all outputs at reset values, ctrl_cs_o = 1; FIFO empty; no done_o or err_o pulse.
- Command: start_i with page_addr_i = 16'hBABE -> ctrl_wr_o high exactly 2 clocks with ctrl_addr_o = 8'h02, ctrl_data_o = 16'hBABE; start_i pulsed again while busy is ignored.
- Full page, PAGE_WORDS = 4:
  - Stimulus: source sends 32'hABCDEF12, +1, +2, +3; engine takes each word the cycle after strobe; eng_done_i pulses 100 clocks later.
  - Required: engine receives the 4 words in order; done_o pulses once, 1 cycle after eng_done_i.
- Backpressure/full:
  - Stimulus: FIFO_DEPTH = 4; source always valid; engine stalled 20 clocks.
  - Required: src_ready_o low after 4 words; simultaneous push/pop at full loses no data; acc_cnt stops at PAGE_WORDS.
- Underrun: source stops after 2 of 4 words -> err_o pulses 4096 clocks after the FIFO empties; FSM returns to IDLE; done_o never pulses.
- Checksum (with NAND_FEEDER_CKSUM_EN): words 1, 2, 4, 8 -> cksum_o = 32'h0000000F at done_o.
